// File: rtl/oscillator_phase_gen_pkg.sv
// Shared types for the per-voice oscillator phase generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the quarter-wave address types, the run-state encoding and the
// default accumulator/LUT address widths.
package oscillator_phase_gen_pkg;

    localparam int PHASE_ACC_WIDTH    = 32;
    localparam int LONG_PERCENT_WIDTH = 10;

    typedef logic [LONG_PERCENT_WIDTH-1:0] long_percent_t;

    // FRONT = rising quarter (quadrants 0,2), BACK = falling quarter (1,3).
    typedef enum logic {FRONT = 1'b0, BACK = 1'b1} oscillator_state_t;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} osc_run_state_t;

    typedef logic [1:0] quadrant_t;

    function automatic oscillator_state_t quad_to_state(input quadrant_t q);
        return q[0] ? BACK : FRONT;
    endfunction

endpackage

// File: rtl/oscillator_phase_gen.sv
// Per-voice phase accumulator feeding the sine LUT: quarter-wave address plus sign.
// Latency: 1 cycle from sample tick to o_sample_valid with the stepped phase.
// Backpressure: none; every tick yields exactly one output sample.
//
// Ports:
//   i_clock, i_reset        clock, asynchronous active-high reset
//   i_sample_tick           one-cycle strobe at the audio sample rate
//   i_note_start/_stop      start (phase 0) / stop at next cycle wrap
//   i_increment, i_increment_load   tuning word and its capture strobe
//   o_state, o_phase, o_negative    quarter-wave address and half-cycle sign
//   o_sample_valid          one-cycle pulse per tick
//   o_active                high while running or draining
module oscillator_phase_gen
    import oscillator_phase_gen_pkg::*;
#(
    parameter int ACC_WIDTH   = PHASE_ACC_WIDTH,
    parameter int PHASE_WIDTH = LONG_PERCENT_WIDTH
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_sample_tick,
    input  logic                   i_note_start,
    input  logic                   i_note_stop,
    input  logic [ACC_WIDTH-1:0]   i_increment,
    input  logic                   i_increment_load,
    output oscillator_state_t      o_state,
    output logic [PHASE_WIDTH-1:0] o_phase,
    output logic                   o_negative,
    output logic                   o_sample_valid,
    output logic                   o_active
);

    osc_run_state_t         r_run;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [ACC_WIDTH-1:0]   r_inc_active;
    logic [ACC_WIDTH-1:0]   r_inc_pending;
    oscillator_state_t      r_state;
    logic [PHASE_WIDTH-1:0] r_phase;
    logic                   r_negative;
    logic                   r_sample_valid;

    osc_run_state_t         w_run_nxt;
    logic [ACC_WIDTH-1:0]   w_acc_nxt;
    logic [ACC_WIDTH-1:0]   w_inc_nxt;
    logic [ACC_WIDTH-1:0]   w_pend_nxt;
    logic [ACC_WIDTH:0]     w_sum;
    logic                   w_carry;
    quadrant_t              w_quad;

    assign w_sum   = {1'b0, r_acc} + {1'b0, r_inc_active};
    assign w_carry = w_sum[ACC_WIDTH];

    // A load in the same cycle as a transfer point is seen immediately,
    // so the most recent tuning word always wins.
    assign w_pend_nxt = i_increment_load ? i_increment : r_inc_pending;

    always_comb begin
        w_run_nxt = r_run;
        w_acc_nxt = r_acc;
        w_inc_nxt = r_inc_active;
        unique case (r_run)
            IDLE: begin
                w_acc_nxt = '0;
                if (i_note_start) begin
                    w_run_nxt = RUN;
                    w_inc_nxt = w_pend_nxt;
                end
            end
            RUN: begin
                if (i_note_start) begin
                    // Restart beats a coincident tick and a coincident stop.
                    w_acc_nxt = '0;
                    w_inc_nxt = w_pend_nxt;
                end else begin
                    if (r_inc_active == '0) begin
                        // A zero step never wraps, so tuning is taken at once.
                        w_inc_nxt = w_pend_nxt;
                    end else if (i_sample_tick) begin
                        w_acc_nxt = w_sum[ACC_WIDTH-1:0];
                        if (w_carry) begin
                            w_inc_nxt = w_pend_nxt;
                        end
                    end
                    if (i_note_stop) begin
                        w_run_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (i_note_start) begin
                    w_run_nxt = RUN;
                    w_acc_nxt = '0;
                    w_inc_nxt = w_pend_nxt;
                end else if (r_inc_active == '0) begin
                    w_run_nxt = IDLE;
                    w_acc_nxt = '0;
                end else if (i_sample_tick) begin
                    if (w_carry) begin
                        // Cycle completed: stop silently at phase 0.
                        w_run_nxt = IDLE;
                        w_acc_nxt = '0;
                        w_inc_nxt = w_pend_nxt;
                    end else begin
                        w_acc_nxt = w_sum[ACC_WIDTH-1:0];
                    end
                end
            end
            default: begin
                w_run_nxt = IDLE;
                w_acc_nxt = '0;
            end
        endcase
    end

    assign w_quad = w_acc_nxt[ACC_WIDTH-1 -: 2];

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_run          <= IDLE;
            r_acc          <= '0;
            r_inc_active   <= '0;
            r_inc_pending  <= '0;
            r_state        <= FRONT;
            r_phase        <= '0;
            r_negative     <= 1'b0;
            r_sample_valid <= 1'b0;
        end else begin
            r_run          <= w_run_nxt;
            r_acc          <= w_acc_nxt;
            r_inc_active   <= w_inc_nxt;
            r_inc_pending  <= w_pend_nxt;
            r_state        <= quad_to_state(w_quad);
            r_phase        <= w_acc_nxt[ACC_WIDTH-3 -: PHASE_WIDTH];
            r_negative     <= w_quad[1];
            r_sample_valid <= i_sample_tick;
        end
    end

    assign o_state        = r_state;
    assign o_phase        = r_phase;
    assign o_negative     = r_negative;
    assign o_sample_valid = r_sample_valid;
    assign o_active       = (r_run != IDLE);

endmodule

// File: tb/tb_oscillator_phase_gen.sv
// Directed bench for oscillator_phase_gen with an expected-sample queue.
// Latency: checks each tick's sample one cycle after the tick.
// Backpressure: n/a.
module tb_oscillator_phase_gen;
    import oscillator_phase_gen_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              tick, start, stop, load;
    logic [31:0]       inc;
    oscillator_state_t st;
    logic [9:0]        ph;
    logic              neg, vld, act;

    int tests = 0;
    int fails = 0;
    logic [11:0] sb_q[$];

    always #5 clk = ~clk;

    oscillator_phase_gen #(.ACC_WIDTH(32), .PHASE_WIDTH(10)) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_sample_tick  (tick),
        .i_note_start   (start),
        .i_note_stop    (stop),
        .i_increment    (inc),
        .i_increment_load(load),
        .o_state        (st),
        .o_phase        (ph),
        .o_negative     (neg),
        .o_sample_valid (vld),
        .o_active       (act)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Apply one cycle of inputs at the falling edge; return just after the rising edge.
    task automatic step(input logic t, input logic s, input logic p, input logic l,
                        input logic [31:0] v);
        @(negedge clk);
        tick = t; start = s; stop = p; load = l; inc = v;
        @(posedge clk);
        #1;
        tick = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0;
    endtask

    // Tick, then pop the expected sample and compare it with the DUT output.
    task automatic tk(input string tag, input logic s_st, input logic [9:0] s_ph,
                      input logic s_ng);
        logic [11:0] e;
        sb_q.push_back({s_st, s_ph, s_ng});
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk({tag, "_vld"}, {31'd0, vld}, 32'd1);
        e = sb_q.pop_front();
        chk(tag, {20'd0, st, ph, neg}, {20'd0, e});
    endtask

    initial begin
        rst = 1'b1; tick = 0; start = 0; stop = 0; load = 0; inc = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out", {20'd0, st, ph, neg}, 32'd0);
        chk("rst_vld", {30'd0, vld, act}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Quarter-turn steps walk all four quadrants and wrap.
        step(0, 0, 0, 1, 32'h4000_0000);
        step(0, 1, 0, 0, 32'h0);
        chk("t1_act", {31'd0, act}, 32'd1);
        tk("t1_q1", BACK,  10'h000, 1'b0);
        step(0, 0, 0, 0, 32'h0);
        chk("t1_pulse", {31'd0, vld}, 32'd0);
        tk("t1_q2", FRONT, 10'h000, 1'b1);
        tk("t1_q3", BACK,  10'h000, 1'b1);
        tk("t1_q0", FRONT, 10'h000, 1'b0);

        // Fine step: acc[29:20] of 0x0040_0000 is 0x004; 256 steps reach quadrant 1.
        step(0, 0, 0, 1, 32'h0040_0000);
        step(0, 1, 0, 0, 32'h0);
        tk("t2_first", FRONT, 10'h004, 1'b0);
        for (int i = 0; i < 254; i++) step(1, 0, 0, 0, 32'h0);
        tk("t2_256", BACK, 10'h000, 1'b0);

        // Retune mid-cycle: new step only after the wrap.
        step(0, 0, 0, 1, 32'h4000_0000);
        step(0, 1, 0, 0, 32'h0);
        tk("t3_1", BACK, 10'h000, 1'b0);
        step(0, 0, 0, 1, 32'h2000_0000);
        tk("t3_2", FRONT, 10'h000, 1'b1);
        tk("t3_3", BACK,  10'h000, 1'b1);
        tk("t3_4", FRONT, 10'h000, 1'b0);
        tk("t3_5", FRONT, 10'h200, 1'b0);
        tk("t3_6", BACK,  10'h000, 1'b0);

        // Stop drains to the end of the cycle, then silence.
        step(0, 0, 0, 1, 32'h4000_0000);
        step(0, 1, 0, 0, 32'h0);
        tk("t4_1", BACK, 10'h000, 1'b0);
        step(0, 0, 1, 0, 32'h0);
        chk("t4_act_a", {31'd0, act}, 32'd1);
        tk("t4_2", FRONT, 10'h000, 1'b1);
        tk("t4_3", BACK,  10'h000, 1'b1);
        chk("t4_act_b", {31'd0, act}, 32'd1);
        tk("t4_4", FRONT, 10'h000, 1'b0);
        chk("t4_idle", {31'd0, act}, 32'd0);
        tk("t4_sil", FRONT, 10'h000, 1'b0);
        step(0, 0, 1, 0, 32'h0);
        chk("t4_stop_idle", {31'd0, act}, 32'd0);

        // Start wins over stop; tick with start gives phase 0; async reset.
        step(0, 1, 0, 0, 32'h0);
        tk("t5_1", BACK,  10'h000, 1'b0);
        tk("t5_2", FRONT, 10'h000, 1'b1);
        step(0, 1, 1, 0, 32'h0);
        chk("t5_startwins", {31'd0, act}, 32'd1);
        tk("t5_3", BACK, 10'h000, 1'b0);
        sb_q.push_back({FRONT, 10'h000, 1'b0});
        step(1, 1, 0, 0, 32'h0);
        chk("t5_tstart_vld", {31'd0, vld}, 32'd1);
        chk("t5_tstart", {20'd0, st, ph, neg}, {20'd0, sb_q.pop_front()});
        tk("t5_4", BACK,  10'h000, 1'b0);
        tk("t5_5", FRONT, 10'h000, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_arst", {19'd0, st, ph, neg, act}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Zero step in RUN takes the new tuning word straight away.
        step(0, 1, 0, 0, 32'h0);
        chk("t6_act", {31'd0, act}, 32'd1);
        step(0, 0, 0, 1, 32'h1000_0000);
        step(0, 0, 0, 0, 32'h0);
        tk("t6_1", FRONT, 10'h100, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
